keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad, synchronises and debounces it, and emits one single-cycle event per accepted press.
//   Directly upstream of the calculator operand registers: num_pressed/digit feed operand entry, op_selected/op_code feed the
//   operator latch, eq_pressed/clr_pressed go to the sequencing control. No auto-repeat, no multi-key (ghost) acceptance.
// PARAMETERS
//   SCAN_DIV        50000  clk cycles per column slot; legal values are >= 4
//   DEBOUNCE_SCANS  4      consecutive identical full scans needed to accept a press or a release; legal values are >= 1
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   clear        in   1  asynchronous, active-low reset
//   row_in       in   4  keypad rows, active-low (pulled up), asynchronous to clk
//   col_out      out  4  keypad column drive, active-low one-hot
//   num_pressed  out  1  1-cycle pulse: digit key accepted
//   digit        out  4  value 0..9 of last accepted digit key, held until next digit key
//   op_selected  out  1  1-cycle pulse: operator key accepted
//   op_code      out  2  last accepted operator: 00 '+', 01 '-', 10 '*', 11 '/', held
//   eq_pressed   out  1  1-cycle pulse: '=' accepted
//   clr_pressed  out  1  1-cycle pulse: 'C' accepted
// BEHAVIOUR
//   Reset (clear=0, async): col_out=4'b1110, all pulses 0, digit=0, op_code=0, sync FFs=4'hF, counters=0, FSM=IDLE.
//   Sync: row_in passes through 2 FFs before use.
//   Column timing: div_cnt counts 0..SCAN_DIV-1. Wrapping advances col_idx 0->1->2->3->0. col_out=~(4'b1<<col_idx).
//   Sampling: synced rows are sampled on the cycle div_cnt==SCAN_DIV-1 (settling time >= 2 sync cycles).
//   Key at (row r, column c) is active when row_in[r]=0 while column c is driven; code = 4*r + c.
//   Layout: r0: 1 2 3 +  | r1: 4 5 6 -  | r2: 7 8 9 *  | r3: C 0 = /
//   Scan result: produced after the column-3 sample. NONE = 0 keys, ONE(k) = exactly 1 key, MULTI = 2 or more keys.
//     MULTI is handled exactly like NONE for acceptance, but does not count as NONE for release.
//   FSM, evaluated once per scan result:
//     IDLE:     ONE(k) -> DEBOUNCE, cand=k, cnt=1 (if DEBOUNCE_SCANS==1, accept immediately and go to HELD)
//     DEBOUNCE: ONE(cand) -> cnt+1; on reaching DEBOUNCE_SCANS, accept cand and go to HELD;
//               any other result -> IDLE, no event
//     HELD:     NONE -> RELEASE, cnt=1; anything else -> stay (no repeat)
//     RELEASE:  NONE -> cnt+1; on reaching DEBOUNCE_SCANS -> IDLE; any non-NONE -> HELD
//   Accept: exactly one of the 4 pulses is high for exactly 1 cycle, the cycle after the deciding scan result.
//     digit/op_code update in that same cycle. Other held outputs are unchanged.
//   Latency: a clean press that is stable from scan start produces its pulse within
//     (DEBOUNCE_SCANS+1)*4*SCAN_DIV+4 cycles.
//   Press then release then press of the same key produces 2 events. A key held while another is added
//     produces no new event (stays in HELD).
//   Reset mid-operation: any pending candidate is dropped, no pulse is emitted. A key held through reset release
//     is re-debounced from IDLE and reported exactly once.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3; the bench models the matrix as row r low while its pressed column is driven low)
//   1. Reset with clear=0 -> col_out=1110, all pulses 0, digit=0, op_code=00. Release reset -> col_out rotates
//      1101, 1011, 0111 every 4 clk.
//   2. Hold '7' (r2,c0) for 20 scans -> exactly 1 num_pressed with digit=7, within 68 cycles; no repeat while held.
//   3. '5' bounces (toggling every 5 clk) for 2 scans, then is stable -> exactly 1 num_pressed, digit=5.
//   4. '1' and '2' held together for 10 scans -> no pulse. Release '2' only -> 1 num_pressed, digit=1.
//   5. Press/release '*' -> op_selected, op_code=10. Then 'C' -> only clr_pressed. Then '=' -> only eq_pressed.
//      digit and op_code stay unchanged across the C and '=' presses.
//   6. Hold '9'; assert clear during DEBOUNCE (cnt=2) -> no pulse. Deassert clear with '9' still held ->
//      exactly 1 num_pressed, digit=9.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronises the rows, rotates the column drive,
// debounces whole-keypad scan results and emits one single-cycle event per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       num_pressed,
  output logic [3:0] digit,
  output logic       op_selected,
  output logic [1:0] op_code,
  output logic       eq_pressed,
  output logic       clr_pressed
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TOP  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_acc_cnt;
  logic [3:0]    r_acc_code;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic          r_num, r_op, r_eq, r_clr;
  logic [3:0]    r_digit;
  logic [1:0]    r_op_code;

  logic          w_sample, w_scan_done, w_none, w_one, w_accept;
  logic [3:0]    w_rows;
  logic [2:0]    w_col_cnt, w_sum;
  logic [1:0]    w_col_row, w_scan_cnt;
  logic [3:0]    w_scan_code;
  state_t        w_state_next;
  logic [3:0]    w_cand_next;
  logic [CW-1:0] w_cnt_next, w_cnt_inc;
  logic [1:0]    w_key_row, w_key_col;
  logic [3:0]    w_digit_val;

  assign col_out  = ~(4'b0001 << r_col_idx);
  assign w_sample = (r_div_cnt == DIV_LAST);
  assign w_rows   = ~r_sync2;

  // Count active rows in the current column; the downward loop leaves the lowest active row.
  always_comb begin
    w_col_cnt = 3'd0;
    w_col_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rows[i]) begin
        w_col_cnt = w_col_cnt + 3'd1;
        w_col_row = 2'(i);
      end
    end
  end

  // Key count saturates at 2, which stands for "two or more" (ghosting / multi-key).
  assign w_sum       = {1'b0, r_acc_cnt} + w_col_cnt;
  assign w_scan_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_scan_code = (r_acc_cnt == 2'd0) ? {w_col_row, r_col_idx} : r_acc_code;
  assign w_scan_done = w_sample && (r_col_idx == 2'd3);
  assign w_none      = (w_scan_cnt == 2'd0);
  assign w_one       = (w_scan_cnt == 2'd1);
  assign w_cnt_inc   = r_cnt + CW'(1);

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: if (w_one) begin
          w_cand_next = w_scan_code;
          w_cnt_next  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            w_accept     = 1'b1;
            w_state_next = S_HELD;
          end else begin
            w_state_next = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: if (w_one && (w_scan_code == r_cand)) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_TOP) begin
            w_accept     = 1'b1;
            w_state_next = S_HELD;
          end
        end else begin
          w_state_next = S_IDLE;
        end
        S_HELD: if (w_none) begin
          w_cnt_next   = CW'(1);
          w_state_next = S_RELEASE;
        end
        S_RELEASE: if (w_none) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc >= CNT_TOP) w_state_next = S_IDLE;
        end else begin
          w_state_next = S_HELD;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign w_key_row   = w_cand_next[3:2];
  assign w_key_col   = w_cand_next[1:0];
  assign w_digit_val = 4'({2'b00, w_key_row} * 4'd3 + {2'b00, w_key_col} + 4'd1);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_div_cnt  <= '0;
      r_col_idx  <= 2'd0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
      r_state    <= S_IDLE;
      r_cand     <= 4'd0;
      r_cnt      <= '0;
      r_num      <= 1'b0;
      r_op       <= 1'b0;
      r_eq       <= 1'b0;
      r_clr      <= 1'b0;
      r_digit    <= 4'd0;
      r_op_code  <= 2'd0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        r_div_cnt <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_scan_cnt;
          r_acc_code <= w_scan_code;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
      r_state <= w_state_next;
      r_cand  <= w_cand_next;
      r_cnt   <= w_cnt_next;
      r_num   <= 1'b0;
      r_op    <= 1'b0;
      r_eq    <= 1'b0;
      r_clr   <= 1'b0;
      // Column 3 holds the operators; row 3 holds C, 0 and '='.
      if (w_accept) begin
        if (w_key_col == 2'd3) begin
          r_op      <= 1'b1;
          r_op_code <= w_key_row;
        end else if (w_key_row == 2'd3) begin
          case (w_key_col)
            2'd0:    r_clr <= 1'b1;
            2'd1:    begin r_num <= 1'b1; r_digit <= 4'd0; end
            default: r_eq  <= 1'b1;
          endcase
        end else begin
          r_num   <= 1'b1;
          r_digit <= w_digit_val;
        end
      end
    end
  end

  assign num_pressed = r_num;
  assign op_selected = r_op;
  assign eq_pressed  = r_eq;
  assign clr_pressed = r_clr;
  assign digit       = r_digit;
  assign op_code     = r_op_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model drives the rows, a key-set level reference model
// predicts every output each cycle, and directed plus random presses exercise the debouncer.
module tb_keypad_scanner;
  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        num_pressed, op_selected, eq_pressed, clr_pressed;
  logic [3:0]  digit;
  logic [1:0]  op_code;
  logic [15:0] keys = 16'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_num = 0, n_op = 0, n_eq = 0, n_clr = 0;
  int b_num, b_op, b_eq, b_clr;
  int first_num_cyc = -1;

  // Key meanings by code 4*r+c: 0..9 digits, 10..13 + - * /, 14 C, 15 =.
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int         mt;
  logic [3:0] h1, h2;
  int         scan_n, scan_k;
  bit         held;
  int         run_len, run_key, none_run;
  logic       exp_num, exp_op, exp_eq, exp_clr;
  logic [3:0] exp_digit;
  logic [1:0] exp_opc;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .clear(clear), .row_in(row_in), .col_out(col_out),
    .num_pressed(num_pressed), .digit(digit), .op_selected(op_selected),
    .op_code(op_code), .eq_pressed(eq_pressed), .clr_pressed(clr_pressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if ((keys[4*r +: 4] & ~col_out) != 4'b0) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] rows_seen(input logic [15:0] k, input int col);
    logic [3:0] v = 4'hF;
    for (int r = 0; r < 4; r++) if (k[4*r+col]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    mt = 0; h1 = 4'hF; h2 = 4'hF; scan_n = 0; scan_k = 0;
    held = 0; run_len = 0; run_key = 0; none_run = 0;
    exp_num = 0; exp_op = 0; exp_eq = 0; exp_clr = 0; exp_digit = 0; exp_opc = 0;
  endtask

  task automatic fire(input int k);
    int v = layout[k];
    if (v < 10) begin exp_num = 1; exp_digit = 4'(v); end
    else if (v <= 13) begin exp_op = 1; exp_opc = 2'(v - 10); end
    else if (v == 14) exp_clr = 1;
    else exp_eq = 1;
  endtask

  task automatic evaluate(input int n, input int k);
    if (!held) begin
      if (n == 1) begin
        if (run_len > 0 && k != run_key) run_len = 0;
        else begin run_key = k; run_len++; end
        if (run_len == DS) begin held = 1; none_run = 0; run_len = 0; fire(k); end
      end else run_len = 0;
    end else begin
      if (n == 0) begin none_run++; if (none_run == DS) held = 0; end
      else none_run = 0;
    end
  endtask

  task automatic model_step();
    int col = (mt / SD) % 4;
    logic [3:0] s = h2;
    h2 = h1;
    h1 = rows_seen(keys, col);
    exp_num = 0; exp_op = 0; exp_eq = 0; exp_clr = 0;
    if (mt % SD == SD - 1) begin
      for (int r = 0; r < 4; r++) if (!s[r]) begin
        scan_n++;
        if (scan_n == 1) scan_k = 4 * r + col;
      end
      if (col == 3) begin evaluate(scan_n, scan_k); scan_n = 0; end
    end
    mt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge clear);
      if (!clear) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("col_out", col_out, 4'(~(4'b0001 << ((mt / SD) % 4))));
      check("num_pressed", num_pressed, exp_num);
      check("op_selected", op_selected, exp_op);
      check("eq_pressed", eq_pressed, exp_eq);
      check("clr_pressed", clr_pressed, exp_clr);
      check("digit", digit, exp_digit);
      check("op_code", op_code, exp_opc);
      n_num += num_pressed; n_op += op_selected; n_eq += eq_pressed; n_clr += clr_pressed;
      if (num_pressed && first_num_cyc < 0) first_num_cyc = cyc;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic snap();
    b_num = n_num; b_op = n_op; b_eq = n_eq; b_clr = n_clr; first_num_cyc = -1;
  endtask

  task automatic tap(input int k, input int hold_scans, input int rel_scans);
    keys[k] = 1'b1; cyc_wait(hold_scans * SCAN);
    keys = 16'h0;   cyc_wait(rel_scans * SCAN);
  endtask

  initial begin
    int press_cyc;
    cyc_wait(3);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_pulses", {num_pressed, op_selected, eq_pressed, clr_pressed}, 0);
    check("rst_digit", digit, 0);
    check("rst_op_code", op_code, 0);
    clear = 1'b1;
    @(negedge clk); check("rot_c0", col_out, 4'b1110);
    repeat (4) @(negedge clk); check("rot_c1", col_out, 4'b1101);
    repeat (4) @(negedge clk); check("rot_c2", col_out, 4'b1011);
    repeat (4) @(negedge clk); check("rot_c3", col_out, 4'b0111);
    #2;
    $display("test1 reset and column rotation done");

    snap(); press_cyc = cyc;
    tap(8, 20, 6);
    check("t2_num_count", n_num - b_num, 1);
    check("t2_digit", digit, 7);
    check("t2_latency_ok", (first_num_cyc >= 0 && first_num_cyc - press_cyc <= 68) ? 1 : 0, 1);
    check("t2_other", (n_op - b_op) + (n_eq - b_eq) + (n_clr - b_clr), 0);
    $display("test2 key 7 held: events=%0d latency=%0d", n_num - b_num, first_num_cyc - press_cyc);

    snap();
    for (int j = 0; j < 6; j++) begin keys[5] = ~keys[5]; cyc_wait(5); end
    tap(5, 10, 6);
    check("t3_num_count", n_num - b_num, 1);
    check("t3_digit", digit, 5);
    $display("test3 bouncing key 5: events=%0d", n_num - b_num);

    snap();
    keys[0] = 1'b1; keys[1] = 1'b1; cyc_wait(10 * SCAN);
    check("t4_multi_none", n_num - b_num, 0);
    keys[1] = 1'b0; cyc_wait(8 * SCAN);
    keys = 16'h0;   cyc_wait(6 * SCAN);
    check("t4_num_count", n_num - b_num, 1);
    check("t4_digit", digit, 1);
    $display("test4 keys 1+2 then 1: events=%0d", n_num - b_num);

    snap();
    tap(11, 6, 6);
    check("t5_op_count", n_op - b_op, 1);
    check("t5_op_code", op_code, 2);
    tap(12, 6, 6);
    check("t5_clr_count", n_clr - b_clr, 1);
    tap(14, 6, 6);
    check("t5_eq_count", n_eq - b_eq, 1);
    check("t5_num_none", n_num - b_num, 0);
    check("t5_digit_kept", digit, 1);
    check("t5_op_kept", op_code, 2);
    $display("test5 op/C/=: op=%0d clr=%0d eq=%0d", n_op - b_op, n_clr - b_clr, n_eq - b_eq);

    snap();
    for (int j = 0; j < SCAN && (mt % SCAN) != 0; j++) cyc_wait(1);
    keys[10] = 1'b1; cyc_wait(2 * SCAN + 8);
    clear = 1'b0; cyc_wait(5);
    check("t6_no_pulse", n_num - b_num, 0);
    clear = 1'b1; cyc_wait(8 * SCAN);
    keys = 16'h0;  cyc_wait(6 * SCAN);
    check("t6_num_count", n_num - b_num, 1);
    check("t6_digit", digit, 9);
    $display("test6 reset during debounce: events=%0d", n_num - b_num);

    for (int t = 0; t < 10; t++) begin
      int k = $urandom_range(0, 15);
      int k2 = $urandom_range(0, 15);
      int hold = $urandom_range(2, 8);
      int rel = $urandom_range(1, 6);
      bit bounce = 1'($urandom_range(0, 1));
      bit extra = ($urandom_range(0, 2) == 0);
      snap();
      if (bounce) for (int j = 0; j < 6; j++) begin keys[k] = ~keys[k]; cyc_wait(5); end
      keys[k] = 1'b1; cyc_wait((hold / 2) * SCAN);
      if (extra) keys[k2] = 1'b1;
      cyc_wait((hold - hold / 2) * SCAN);
      keys = 16'h0; cyc_wait(rel * SCAN);
      $display("txn %0d key=%0d hold=%0d rel=%0d bounce=%0d extra=%0d events num=%0d op=%0d eq=%0d clr=%0d",
               t, k, hold, rel, bounce, extra, n_num - b_num, n_op - b_op, n_eq - b_eq, n_clr - b_clr);
    end
    cyc_wait(6 * SCAN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
